// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 25;
   localparam int LINE_W_DEF = 128;
   localparam int WD_W       = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_e;

endpackage

// File: rtl/ram_arb_wd.sv
// RAM watchdog: counts cycles of an active grant and flags expiry on the
// WD_CYCLES-th granted cycle. Only instantiated with RAM_ARB_WATCHDOG_EN.
module ram_arb_wd
   import ram_arb_pkg::*;
#(
   parameter int WD_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   output logic expire_o
);

   logic [WD_W-1:0] cnt_q, cnt_d;

   // The counter sits at zero whenever no grant is active, so every new grant starts fresh.
   always_comb begin
      cnt_d = '0;
      if (run_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expire_o = run_i && (cnt_q == WD_W'(WD_CYCLES - 1));

endmodule

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one 128-bit-line RAM port between instruction
// fetch and data memory. Optional watchdog: define RAM_ARB_WATCHDOG_EN.
module ram_arb
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LINE_W    = LINE_W_DEF,
   parameter int WD_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_stb,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [LINE_W-1:0] inst_dout,
   output logic              inst_ack,
   output logic              inst_timeout,
   input  logic              data_stb,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [LINE_W-1:0] data_din,
   output logic [LINE_W-1:0] data_dout,
   output logic              data_ack,
   output logic              data_timeout,
   output logic              ram_stb,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [LINE_W-1:0] ram_din,
   input  logic [LINE_W-1:0] ram_dout,
   input  logic              ram_ack,
   input  logic              ram_timeout
);

   if (WD_CYCLES < 1 || WD_CYCLES > 255) begin : g_bad_wd
      $error("ram_arb: WD_CYCLES must fit the 8-bit watchdog counter");
   end

   state_e state_q, state_d;
   logic   last_d_q, last_d_d;
   logic   own_i, own_d;
   logic   wd_expire;
   logic   owner_to;

   // Reset masks ownership at once so an abandoned transaction never sees ack/timeout.
   assign own_i = !rst && (state_q == GNT_I);
   assign own_d = !rst && (state_q == GNT_D);

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      case (state_q)
         IDLE: begin
            if (inst_stb && (!data_stb || last_d_q)) begin
               state_d  = GNT_I;
               last_d_d = 1'b0;
            end else if (data_stb) begin
               state_d  = GNT_D;
               last_d_d = 1'b1;
            end
         end
         GNT_I, GNT_D: begin
            if (ram_ack || ram_timeout || wd_expire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
      end
   end

`ifdef RAM_ARB_WATCHDOG_EN
   ram_arb_wd #(
      .WD_CYCLES (WD_CYCLES)
   ) u_wd (
      .clk      (clk),
      .rst      (rst),
      .run_i    (own_i || own_d),
      .expire_o (wd_expire)
   );
`else
   assign wd_expire = 1'b0;
`endif

   // Watchdog expiry looks like a RAM timeout to the owner and withdraws the request.
   assign owner_to = ram_timeout || wd_expire;

   assign ram_stb  = ((own_i && inst_stb) || (own_d && data_stb)) && !wd_expire;
   assign ram_we   = own_d && data_we;
   assign ram_addr = own_i ? inst_addr : data_addr;
   assign ram_din  = data_din;

   assign inst_ack     = own_i && ram_ack && !owner_to;
   assign inst_timeout = own_i && owner_to;
   assign data_ack     = own_d && ram_ack && !owner_to;
   assign data_timeout = own_d && owner_to;

   assign inst_dout = ram_dout;
   assign data_dout = ram_dout;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed scenarios followed by randomized traffic,
// every cycle checked against a transaction-level reference model.
module tb_ram_arb;

   localparam int AW = 25;
   localparam int LW = 128;
`ifdef RAM_ARB_WATCHDOG_EN
   localparam int WD   = 8;
   localparam int RMAX = 10;
`else
   localparam int WD   = 255;
   localparam int RMAX = 4;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          inst_stb, inst_ack, inst_timeout;
   logic [AW-1:0] inst_addr;
   logic [LW-1:0] inst_dout;
   logic          data_stb, data_we, data_ack, data_timeout;
   logic [AW-1:0] data_addr;
   logic [LW-1:0] data_din, data_dout;
   logic          ram_stb, ram_we, ram_ack, ram_timeout;
   logic [AW-1:0] ram_addr;
   logic [LW-1:0] ram_din, ram_dout;

   ram_arb #(.ADDR_W(AW), .LINE_W(LW), .WD_CYCLES(WD)) dut (
      .clk(clk), .rst(rst),
      .inst_stb(inst_stb), .inst_addr(inst_addr), .inst_dout(inst_dout),
      .inst_ack(inst_ack), .inst_timeout(inst_timeout),
      .data_stb(data_stb), .data_we(data_we), .data_addr(data_addr),
      .data_din(data_din), .data_dout(data_dout),
      .data_ack(data_ack), .data_timeout(data_timeout),
      .ram_stb(ram_stb), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout),
      .ram_ack(ram_ack), .ram_timeout(ram_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the port (0 none, 1 inst, 2 data), who won last,
   // how many cycles the current grant has lasted, and the RAM's pending latency.
   int m_own   = 0;
   bit m_last  = 1'b1;
   int m_gcyc  = 0;
   int ram_wait = 0;

   logic          s_stb, s_we, s_ia, s_it, s_da, s_dt;
   logic [AW-1:0] s_addr;
   logic [LW-1:0] s_din, s_idout;
   bit            e_iend, e_dend;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called just after inputs change on the falling edge; returns on the next falling edge.
   task automatic step();
      logic          xs, xw, xia, xit, xda, xdt, xp;
      logic [AW-1:0] xa;
      xs = 1'b0; xw = 1'b0; xia = 1'b0; xit = 1'b0; xda = 1'b0; xdt = 1'b0; xp = 1'b0;
      xa = '0;
      #1;
      if (!rst && m_own != 0) begin
`ifdef RAM_ARB_WATCHDOG_EN
         xp = (m_gcyc == WD);
`endif
         if (m_own == 1) begin
            xs  = inst_stb && !xp;
            xa  = inst_addr;
            xit = ram_timeout || xp;
            xia = ram_ack && !xit;
         end else begin
            xs  = data_stb && !xp;
            xa  = data_addr;
            xw  = data_we;
            xdt = ram_timeout || xp;
            xda = ram_ack && !xdt;
         end
      end
      s_stb = ram_stb; s_we = ram_we; s_addr = ram_addr; s_din = ram_din;
      s_ia = inst_ack; s_it = inst_timeout; s_da = data_ack; s_dt = data_timeout;
      s_idout = inst_dout;
      chk("ram_stb", LW'(ram_stb), LW'(xs));
      if (rst || m_own != 0) chk("ram_we", LW'(ram_we), LW'(xw));
      if (!rst && m_own != 0) chk("ram_addr", LW'(ram_addr), LW'(xa));
      chk("ram_din", ram_din, data_din);
      chk("inst_dout", inst_dout, ram_dout);
      chk("data_dout", data_dout, ram_dout);
      chk("inst_ack", LW'(inst_ack), LW'(xia));
      chk("inst_timeout", LW'(inst_timeout), LW'(xit));
      chk("data_ack", LW'(data_ack), LW'(xda));
      chk("data_timeout", LW'(data_timeout), LW'(xdt));
      e_iend = xia || xit;
      e_dend = xda || xdt;
      if (rst) begin
         m_own  = 0;
         m_last = 1'b1;
      end else if (m_own == 0) begin
         if (inst_stb && (!data_stb || m_last)) begin
            m_own = 1; m_last = 1'b0; m_gcyc = 1;
            ram_wait = $urandom_range(0, RMAX);
         end else if (data_stb) begin
            m_own = 2; m_last = 1'b1; m_gcyc = 1;
            ram_wait = $urandom_range(0, RMAX);
         end
      end else if (ram_ack || ram_timeout || xp) begin
         m_own = 0;
      end else begin
         m_gcyc++;
      end
      @(negedge clk);
   endtask

   task automatic quiet();
      rst = 1'b0; inst_stb = 1'b0; data_stb = 1'b0; data_we = 1'b0;
      ram_ack = 1'b0; ram_timeout = 1'b0;
   endtask

   logic [127:0] pat;
   logic [LW-1:0] wdat;
   bit   order [6];
   int   n;
   bit   i_pend, d_pend;
   int   r;

   initial begin
      rst = 1'b1; inst_stb = 1'b0; data_stb = 1'b0; data_we = 1'b0;
      inst_addr = '0; data_addr = '0; data_din = '0; ram_dout = '0;
      ram_ack = 1'b0; ram_timeout = 1'b0;
      @(negedge clk);

      // Reset state
      step();
      chk("rst_stb", LW'(s_stb), '0);
      chk("rst_iack", LW'(s_ia), '0);
      chk("rst_dack", LW'(s_da), '0);

      // Single instruction read, RAM answers 3 cycles after ram_stb
      quiet();
      inst_stb = 1'b1; inst_addr = 25'h0000100;
      step();
      chk("t1_turn", LW'(s_stb), '0);
      step();
      chk("t1_stb", LW'(s_stb), LW'(1'b1));
      chk("t1_addr", LW'(s_addr), LW'(25'h0000100));
      chk("t1_we", LW'(s_we), '0);
      step(); step();
      pat = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
      ram_dout = pat; ram_ack = 1'b1;
      step();
      chk("t1_ack", LW'(s_ia), LW'(1'b1));
      chk("t1_dout", s_idout, pat);
      chk("t1_dack", LW'(s_da), '0);
      quiet(); step();

      // Simultaneous requests straight out of reset
      rst = 1'b1; step(); rst = 1'b0;
      inst_stb = 1'b1; inst_addr = 25'h10;
      wdat = {$urandom, $urandom, $urandom, $urandom};
      data_stb = 1'b1; data_we = 1'b1; data_addr = 25'h20; data_din = wdat;
      step();
      ram_ack = 1'b1; step();
      chk("t2_first", LW'(s_addr), LW'(25'h10));
      chk("t2_iack", LW'(s_ia), LW'(1'b1));
      ram_ack = 1'b0; inst_stb = 1'b0;
      step();
      chk("t2_turn", LW'(s_stb), '0);
      ram_ack = 1'b1; step();
      chk("t2_addr", LW'(s_addr), LW'(25'h20));
      chk("t2_we", LW'(s_we), LW'(1'b1));
      chk("t2_din", s_din, wdat);
      chk("t2_dack", LW'(s_da), LW'(1'b1));
      quiet(); step();

      // Continuous requests on both sides alternate, instruction first
      inst_stb = 1'b1; data_stb = 1'b1; data_we = 1'b0; ram_ack = 1'b1; n = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (s_ia || s_da) begin
            if (n < 6) order[n] = s_da;
            n++;
         end
      end
      chk("alt_count", LW'(n), LW'(6));
      for (int k = 0; k < 6; k++) chk("alt_order", LW'(order[k]), LW'(k % 2));
      quiet(); step();

      // Timeout on a data read, then timeout together with ack
      data_stb = 1'b1; data_we = 1'b0; data_addr = 25'h1234;
      step();
      ram_timeout = 1'b1; step();
      chk("t4_dto", LW'(s_dt), LW'(1'b1));
      chk("t4_dack", LW'(s_da), '0);
      chk("t4_ito", LW'(s_it), '0);
      ram_timeout = 1'b0; step();
      ram_timeout = 1'b1; ram_ack = 1'b1; step();
      chk("t4b_dto", LW'(s_dt), LW'(1'b1));
      chk("t4b_dack", LW'(s_da), '0);
      chk("t4b_iack", LW'(s_ia), '0);
      quiet(); step();

      // Reset two cycles into a data grant, instruction request held throughout
      data_stb = 1'b1; data_we = 1'b1; data_addr = 25'h33;
      step(); step(); step();
      rst = 1'b1; inst_stb = 1'b1; inst_addr = 25'h44; ram_ack = 1'b1;
      step();
      chk("t5_rst_stb", LW'(s_stb), '0);
      chk("t5_rst_dack", LW'(s_da), '0);
      rst = 1'b0; ram_ack = 1'b0;
      step();
      chk("t5_idle", LW'(s_stb), '0);
      ram_ack = 1'b1; step();
      chk("t5_regrant", LW'(s_addr), LW'(25'h44));
      chk("t5_iack", LW'(s_ia), LW'(1'b1));
      inst_stb = 1'b0; ram_ack = 1'b0; step();
      ram_ack = 1'b1; step();
      chk("t5_dack", LW'(s_da), LW'(1'b1));
      quiet(); step();

`ifdef RAM_ARB_WATCHDOG_EN
      // RAM never answers: watchdog fires on the 8th granted cycle
      inst_stb = 1'b1; inst_addr = 25'h77;
      step();
      for (int k = 1; k < WD; k++) begin
         step();
         chk("wd_wait_to", LW'(s_it), '0);
      end
      step();
      chk("wd_to", LW'(s_it), LW'(1'b1));
      chk("wd_stb", LW'(s_stb), '0);
      inst_stb = 1'b0; ram_ack = 1'b1; step();
      chk("wd_late_ack", LW'(s_ia), '0);
      quiet(); step();
`endif

      // Randomized traffic
      i_pend = 1'b0; d_pend = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1'b1; inst_addr = AW'($urandom);
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1'b1; data_addr = AW'($urandom);
            data_we = 1'($urandom_range(0, 1));
            data_din = {$urandom, $urandom, $urandom, $urandom};
         end
         inst_stb = i_pend; data_stb = d_pend;
         rst = ($urandom_range(0, 99) == 0);
         ram_dout = {$urandom, $urandom, $urandom, $urandom};
         ram_ack = 1'b0; ram_timeout = 1'b0;
         if (m_own != 0) begin
            if (ram_wait == 0) begin
               r = $urandom_range(0, 7);
               ram_ack = (r != 0);
               ram_timeout = (r < 2);
            end else begin
               ram_wait--;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            ram_ack = 1'b1;
         end
         step();
         if (e_iend) i_pend = 1'b0;
         if (e_dend) d_pend = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
